i2c_cmd_sequencer: RTL and testbench
====================================

# i2c_cmd_sequencer

Drains 32-bit command words from the I2C command FIFO (show-ahead: `dout` is valid whenever not empty, and a `read` pulse pops it) and turns each word into byte-level transfers for the I2C byte engine. Supported commands:
- OV5640-style 16-bit-address register writes;
- programmable delays;
- end-of-sequence markers.

It sits between the FIFO (filled by the camera init ROM or host) and the I2C byte master. It owns NACK retry and error reporting.

## Interface
- `DEV_ADDR`, 7'h3C: 7-bit slave address, sent as {DEV_ADDR, 1'b0}.
- `DELAY_WIDTH`, 24: delay counter width; must be ≤ 24.
- `RETRY_MAX`, 3: retries per write command after NACK; 0 = no retry.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: permits fetching new commands; sampled only in IDLE.
- `abort` in 1: synchronous request to return to IDLE.
- `clear_err` in 1: clears sticky `error`.
- `fifo_dout` in 32: head-of-queue word.
- `fifo_empty` in 1: FIFO empty.
- `fifo_read` out 1: one-cycle pop strobe.
- `byte_valid` out 1: byte offered to engine.
- `byte_data` out 8: byte value.
- `byte_start` out 1: engine emits START before this byte.
- `byte_stop` out 1: engine emits STOP after this byte.
- `byte_ready` in 1: engine accepts the byte when high with `byte_valid`.
- `byte_done` in 1: one-cycle pulse, byte finished on the bus.
- `byte_nack` in 1: qualifies `byte_done`. The engine issues STOP itself on NACK.
- `busy` out 1: state ≠ IDLE.
- `cmd_ok` out 1: pulse, write command completed.
- `cmd_fail` out 1: pulse, write dropped after retries were exhausted.
- `seq_done` out 1: pulse, END marker consumed.
- `error` out 1: sticky. Set with `cmd_fail`; cleared by `clear_err` or `rst`. If `clear_err` and `cmd_fail` occur in the same cycle, set wins.

## Operation
- Command word fields:
  - [31:30] op: 00 WRITE, 01 DELAY, 10 END, 11 NOP.
  - [29:24] ignored.
  - WRITE: [23:8] register address, [7:0] data.
  - DELAY: [DELAY_WIDTH-1:0] = N.
- **IDLE**
  - If `enable && !fifo_empty && !abort`: assert `fifo_read` this cycle, latch `fifo_dout`, clear the retry count, go to DECODE.
- **DECODE** (one cycle)
  - WRITE: byte index 0, go to SEND.
  - DELAY: load counter with N, go to DELAY.
  - END: pulse `seq_done`, go to IDLE.
  - NOP: go to IDLE.
- **SEND**
  - Hold `byte_valid` with byte[idx]:
    - idx 0: {DEV_ADDR,0}, `byte_start`=1.
    - idx 1: addr[15:8].
    - idx 2: addr[7:0].
    - idx 3: data, `byte_stop`=1.
  - On `byte_ready`, go to WAIT. `byte_valid` drops the following cycle.
- **WAIT**
  - On `byte_done && !byte_nack`: if idx==3, pulse `cmd_ok` and go to IDLE; else idx+1 and go to SEND.
  - On `byte_done && byte_nack`: if retry count < RETRY_MAX, increment it, set idx=0, go to SEND (full transaction resent from START). Otherwise pulse `cmd_fail`, set `error`, go to IDLE. The command is consumed and not re-queued.
- **DELAY**
  - Decrement each cycle; exit to IDLE in the cycle the counter reads 0.
  - Total DELAY occupancy is N+1 cycles.
- **abort**
  - Honoured next cycle from DECODE, DELAY, and SEND before acceptance.
  - In WAIT, it is latched and taken after `byte_done`, so the bus is never left mid-byte. No status pulse is issued for the aborted command.
  - Unread FIFO entries are untouched.
- Keep `enable` low to pause after the current command. Commands in flight always complete unless aborted.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- `fifo_read` is a combinational function of state IDLE, `enable`, `!fifo_empty` and `!abort`. At most one pop per command; never pops when empty.
- Minimum WRITE with zero-wait engine (ready in SEND, done one cycle after accept): 1 (IDLE) + 1 (DECODE) + 4×2 = 10 cycles.
- `cmd_ok`, `cmd_fail` and `seq_done` are registered one-cycle pulses, asserted in the cycle after the deciding input.
- `byte_data`, `byte_start` and `byte_stop` are stable while `byte_valid` is high.

## Structure
- Shared package `i2c_seq_pkg`: op codes (OP_WRITE, OP_DELAY, OP_END, OP_NOP), state encoding (IDLE, DECODE, SEND, WAIT, DELAY), field bit positions.
- One natural sub-module, `i2c_seq_timer`: loadable down-counter (DELAY_WIDTH) with a zero flag.

## Test plan
- FIFO holds WRITE 0x3008_82, engine zero-wait → bytes 0x78(start), 0x30, 0x08, 0x82(stop); `cmd_ok` at cycle 10; one `fifo_read`.
- DELAY N=5 followed by END → `busy` for 1+1+6 DELAY cycles, then IDLE, pop, DECODE; `seq_done` pulses once.
- NACK on byte idx 2 every attempt with RETRY_MAX=3 → 4 transactions each starting with 0x78 `byte_start`; then `cmd_fail`, `error`=1; `clear_err` → 0.
- NACK on the first attempt only → second attempt completes, `cmd_ok`, `error` stays 0.
- `abort` during WAIT of idx 1 → waits for `byte_done`, then IDLE; no idx 2 byte; remaining FIFO entries intact; `enable`=0 holds with `fifo_read`=0.
- `rst` asserted mid-DELAY → outputs 0 immediately (async), state IDLE; `fifo_empty`=1 with `enable`=1 → `fifo_read` never asserted.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C command sequencer: command op codes, FSM states,
// command-word field positions and the transmit byte selector.
package i2c_seq_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_DELAY = 2'b01,
    OP_END   = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    SEND   = 3'd2,
    WAIT   = 3'd3,
    DELAY  = 3'd4
  } state_e;

  localparam int unsigned OP_MSB      = 31;
  localparam int unsigned OP_LSB      = 30;
  localparam int unsigned PAYLOAD_MSB = 23;
  localparam int unsigned ADDR_HI_MSB = 23;
  localparam int unsigned ADDR_HI_LSB = 16;
  localparam int unsigned ADDR_LO_MSB = 15;
  localparam int unsigned ADDR_LO_LSB = 8;
  localparam int unsigned DATA_MSB    = 7;
  localparam int unsigned DATA_LSB    = 0;

  localparam logic [1:0] IDX_FIRST = 2'd0;
  localparam logic [1:0] IDX_LAST  = 2'd3;

  // Byte idx of a register-write transaction: slave address (write), addr hi, addr lo, data.
  function automatic logic [7:0] tx_byte(input logic [1:0] idx, input logic [23:0] payload,
                                         input logic [6:0] dev_addr);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {dev_addr, 1'b0};
      2'd1:    b = payload[ADDR_HI_MSB:ADDR_HI_LSB];
      2'd2:    b = payload[ADDR_LO_MSB:ADDR_LO_LSB];
      2'd3:    b = payload[DATA_MSB:DATA_LSB];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable down-counter used for DELAY commands; saturates at zero and flags it.
module i2c_seq_timer #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear beats load beats decrement.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Drains 32-bit command words from a show-ahead FIFO and sequences them into
// byte transfers for an I2C byte engine, with NACK retry and sticky error.
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h3C,
  parameter int unsigned DELAY_WIDTH = 24,
  parameter int unsigned RETRY_MAX   = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        abort_i,
  input  logic        clear_err_i,
  input  logic [31:0] fifo_dout_i,
  input  logic        fifo_empty_i,
  output logic        fifo_read_o,
  output logic        byte_valid_o,
  output logic [7:0]  byte_data_o,
  output logic        byte_start_o,
  output logic        byte_stop_o,
  input  logic        byte_ready_i,
  input  logic        byte_done_i,
  input  logic        byte_nack_i,
  output logic        busy_o,
  output logic        cmd_ok_o,
  output logic        cmd_fail_o,
  output logic        seq_done_o,
  output logic        error_o
);

  localparam logic [7:0] RETRY_LIM = 8'(RETRY_MAX);

  state_e      state_q;
  op_e         op_q;
  logic [23:0] payload_q;
  logic [1:0]  idx_q;
  logic [7:0]  retry_q;
  logic        abort_pend_q;
  logic        byte_valid_q, byte_start_q, byte_stop_q;
  logic [7:0]  byte_data_q;
  logic        cmd_ok_q, cmd_fail_q, seq_done_q, error_q;
  logic        tmr_zero_s;
  logic        unused_ok_s;

  assign unused_ok_s = &{1'b0, fifo_dout_i[29:24]};

  assign fifo_read_o = (state_q == IDLE) && enable_i && !fifo_empty_i && !abort_i;

  i2c_seq_timer #(.WIDTH(DELAY_WIDTH)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     ((state_q == DECODE) && (op_q == OP_DELAY)),
    .load_val_i (payload_q[DELAY_WIDTH-1:0]),
    .dec_i      (state_q == DELAY),
    .clr_i      ((state_q == DELAY) && abort_i),
    .zero_o     (tmr_zero_s)
  );

  // Sequencer FSM with registered byte-interface and status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      op_q         <= OP_NOP;
      payload_q    <= 24'h000000;
      idx_q        <= 2'd0;
      retry_q      <= 8'd0;
      abort_pend_q <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      byte_start_q <= 1'b0;
      byte_stop_q  <= 1'b0;
      cmd_ok_q     <= 1'b0;
      cmd_fail_q   <= 1'b0;
      seq_done_q   <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      cmd_ok_q   <= 1'b0;
      cmd_fail_q <= 1'b0;
      seq_done_q <= 1'b0;
      // A cmd_fail in the same cycle overrides this clear (later assignment).
      if (clear_err_i) begin
        error_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (fifo_read_o) begin
            op_q         <= op_e'(fifo_dout_i[OP_MSB:OP_LSB]);
            payload_q    <= fifo_dout_i[PAYLOAD_MSB:0];
            retry_q      <= 8'd0;
            abort_pend_q <= 1'b0;
            state_q      <= DECODE;
          end
        end
        DECODE: begin
          if (abort_i) begin
            state_q <= IDLE;
          end else begin
            case (op_q)
              OP_WRITE: begin
                idx_q        <= IDX_FIRST;
                byte_valid_q <= 1'b1;
                byte_data_q  <= tx_byte(IDX_FIRST, payload_q, DEV_ADDR);
                byte_start_q <= 1'b1;
                byte_stop_q  <= 1'b0;
                state_q      <= SEND;
              end
              OP_DELAY: state_q <= DELAY;
              OP_END: begin
                seq_done_q <= 1'b1;
                state_q    <= IDLE;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        SEND: begin
          // Once the engine takes the byte, abort must wait for byte_done.
          if (byte_ready_i) begin
            byte_valid_q <= 1'b0;
            byte_start_q <= 1'b0;
            byte_stop_q  <= 1'b0;
            abort_pend_q <= abort_i;
            state_q      <= WAIT;
          end else if (abort_i) begin
            byte_valid_q <= 1'b0;
            byte_start_q <= 1'b0;
            byte_stop_q  <= 1'b0;
            state_q      <= IDLE;
          end
        end
        WAIT: begin
          if (byte_done_i) begin
            abort_pend_q <= 1'b0;
            if (abort_i || abort_pend_q) begin
              state_q <= IDLE;
            end else if (!byte_nack_i) begin
              if (idx_q == IDX_LAST) begin
                cmd_ok_q <= 1'b1;
                state_q  <= IDLE;
              end else begin
                idx_q        <= idx_q + 2'd1;
                byte_valid_q <= 1'b1;
                byte_data_q  <= tx_byte(idx_q + 2'd1, payload_q, DEV_ADDR);
                byte_start_q <= 1'b0;
                byte_stop_q  <= ((idx_q + 2'd1) == IDX_LAST);
                state_q      <= SEND;
              end
            end else if (retry_q < RETRY_LIM) begin
              retry_q      <= retry_q + 8'd1;
              idx_q        <= IDX_FIRST;
              byte_valid_q <= 1'b1;
              byte_data_q  <= tx_byte(IDX_FIRST, payload_q, DEV_ADDR);
              byte_start_q <= 1'b1;
              byte_stop_q  <= 1'b0;
              state_q      <= SEND;
            end else begin
              cmd_fail_q <= 1'b1;
              error_q    <= 1'b1;
              state_q    <= IDLE;
            end
          end else if (abort_i) begin
            abort_pend_q <= 1'b1;
          end
        end
        DELAY: begin
          if (abort_i || tmr_zero_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign byte_valid_o = byte_valid_q;
  assign byte_data_o  = byte_data_q;
  assign byte_start_o = byte_start_q;
  assign byte_stop_o  = byte_stop_q;
  assign cmd_ok_o     = cmd_ok_q;
  assign cmd_fail_o   = cmd_fail_q;
  assign seq_done_o   = seq_done_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: FIFO and byte-engine models, byte scoreboard,
// a command vector table and hand-written abort/reset/error sequences.
module tb_i2c_cmd_sequencer;

  localparam int RETRY_MAX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0, abort = 1'b0, clear_err = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_dout = 32'h0;
  logic        byte_ready = 1'b1, byte_done = 1'b0, byte_nack = 1'b0;
  logic        fifo_read, byte_valid, byte_start, byte_stop;
  logic        busy, cmd_ok, cmd_fail, seq_done, error;
  logic [7:0]  byte_data;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_pop = 0, pop_cyc = 0, n_ok = 0, n_cfail = 0, n_done = 0, n_acc = 0;
  bit rd_pending = 1'b0;
  logic [31:0] fifo_q[$];
  logic [9:0]  exp_q[$];
  int done_lat = 1, nack_idx = 0, nack_att = 0, attempt = 0;
  int done_cnt = 0, bidx = 0;
  bit nack_pend = 1'b0;

  typedef struct {
    logic [31:0] word;
    int nidx;
    int natt;
    int exp_ok;
    int exp_fail;
    int exp_done;
    int exp_lat;
    bit exp_err;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  i2c_cmd_sequencer dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .abort_i(abort), .clear_err_i(clear_err),
    .fifo_dout_i(fifo_dout), .fifo_empty_i(fifo_empty), .fifo_read_o(fifo_read),
    .byte_valid_o(byte_valid), .byte_data_o(byte_data), .byte_start_o(byte_start),
    .byte_stop_o(byte_stop), .byte_ready_i(byte_ready), .byte_done_i(byte_done),
    .byte_nack_i(byte_nack), .busy_o(busy), .cmd_ok_o(cmd_ok), .cmd_fail_o(cmd_fail),
    .seq_done_o(seq_done), .error_o(error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expected byte stream for a WRITE word given where and how often the engine NACKs.
  task automatic push_expected(input logic [31:0] w, input int nidx, input int natt);
    logic [7:0] b[4];
    int last;
    if (w[31:30] != 2'b00) return;
    b[0] = 8'h78; b[1] = w[23:16]; b[2] = w[15:8]; b[3] = w[7:0];
    for (int a = 1; a <= RETRY_MAX + 1; a++) begin
      last = (a <= natt) ? nidx : 3;
      for (int i = 0; i <= last; i++) exp_q.push_back({(i == 0), b[i], (i == 3)});
      if (a > natt) break;
    end
  endtask

  // FIFO model: pop on a strobe seen in the previous cycle, present show-ahead head.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (rd_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    rd_pending = 1'b0;
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
  end

  // Byte-engine model and monitor, sampled mid-cycle.
  initial forever begin
    logic [9:0] got, e;
    @(negedge clk);
    byte_done = 1'b0;
    byte_nack = 1'b0;
    if (rst) begin
      done_cnt = 0;
      rd_pending = 1'b0;
    end else begin
      if (cmd_ok) n_ok++;
      if (cmd_fail) n_cfail++;
      if (seq_done) n_done++;
      if (fifo_read) begin
        n_pop++;
        pop_cyc = cyc;
        check("pop_when_empty", {31'h0, fifo_empty}, 32'h0);
      end
      rd_pending = fifo_read;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          byte_done = 1'b1;
          byte_nack = nack_pend;
        end
      end
      if (byte_valid && byte_ready) begin
        n_acc++;
        got = {byte_start, byte_data, byte_stop};
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL byte_extra: got %h, no byte expected", got);
        end else begin
          e = exp_q.pop_front();
          check("byte", {22'h0, got}, {22'h0, e});
        end
        if (byte_start) begin
          attempt++;
          bidx = 0;
        end else begin
          bidx++;
        end
        nack_pend = (attempt <= nack_att) && (bidx == nack_idx);
        done_cnt = done_lat;
      end
    end
  end

  // Wait (bounded) for one pop, then for busy to fall; lat = cycles from pop to IDLE.
  task automatic exec_cmd(input int p0, output int lat);
    int t;
    t = 0;
    while (n_pop == p0 && t < 50) begin tick(); t++; end
    t = 0;
    while (busy && t < 300) begin tick(); t++; end
    lat = (n_pop == p0) ? -1 : cyc - pop_cyc;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int p0, ok0, f0, d0, lat;
    nack_idx = v.nidx; nack_att = v.natt; attempt = 0;
    push_expected(v.word, v.nidx, v.natt);
    p0 = n_pop; ok0 = n_ok; f0 = n_cfail; d0 = n_done;
    fifo_q.push_back(v.word);
    exec_cmd(p0, lat);
    tick();
    check($sformatf("v%0d_latency", k), lat, v.exp_lat);
    check($sformatf("v%0d_cmd_ok", k), n_ok - ok0, v.exp_ok);
    check($sformatf("v%0d_cmd_fail", k), n_cfail - f0, v.exp_fail);
    check($sformatf("v%0d_seq_done", k), n_done - d0, v.exp_done);
    check($sformatf("v%0d_pops", k), n_pop - p0, 1);
    check($sformatf("v%0d_error", k), {31'h0, error}, {31'h0, v.exp_err});
    check($sformatf("v%0d_bytes_left", k), exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, a0, ok0, f0, lat, t;
    //               word          nidx natt ok fail done lat err
    vecs[0] = '{32'h0030_0882,  0,  0,  1, 0, 0, 10, 1'b0};
    vecs[1] = '{32'h0012_3456,  2, 99,  0, 1, 0, 26, 1'b1};
    vecs[2] = '{32'h00AB_CDEF,  0,  1,  1, 0, 0, 12, 1'b0};
    vecs[3] = '{32'h4000_0005,  0,  0,  0, 0, 0,  8, 1'b0};
    vecs[4] = '{32'h8000_0000,  0,  0,  0, 0, 1,  2, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF,  0,  0,  0, 0, 0,  2, 1'b0};
    vecs[6] = '{32'h4000_0000,  0,  0,  0, 0, 0,  3, 1'b0};
    vecs[7] = '{32'h3F55_AA01,  3,  3,  1, 0, 0, 34, 1'b0};
    vecs[8] = '{32'h7F00_0003,  0,  0,  0, 0, 0,  6, 1'b0};

    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", {15'h0, fifo_read, byte_valid, byte_start, byte_stop, busy, cmd_ok,
                            cmd_fail, seq_done, error, byte_data}, 32'h0);
    rst = 1'b0;
    tick();
    enable = 1'b1;

    for (int k = 0; k < 9; k++) begin
      run_vec(vecs[k], k);
      if (vecs[k].exp_err) begin
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check($sformatf("v%0d_clear_err", k), {31'h0, error}, 32'h0);
      end
    end

    // clear_err held through a failing write: set must win in the cmd_fail cycle.
    nack_idx = 0; nack_att = 99; attempt = 0;
    push_expected(32'h0001_0203, 0, 99);
    clear_err = 1'b1;
    p0 = n_pop;
    fifo_q.push_back(32'h0001_0203);
    exec_cmd(p0, lat);
    check("setwins_fail_pulse", {30'h0, cmd_fail, error}, 32'h3);
    clear_err = 1'b0;
    tick();
    check("setwins_error_held", {31'h0, error}, 32'h1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("setwins_cleared", {31'h0, error}, 32'h0);

    // Abort in WAIT of idx 1: finish the byte, stop, leave the next FIFO entry alone.
    nack_att = 0; attempt = 0; done_lat = 4;
    exp_q.push_back({1'b1, 8'h78, 1'b0});
    exp_q.push_back({1'b0, 8'h11, 1'b0});
    ok0 = n_ok; f0 = n_cfail; a0 = n_acc;
    fifo_q.push_back(32'h0011_2233);
    fifo_q.push_back(32'h0044_5566);
    t = 0;
    while (n_acc < a0 + 2 && t < 100) begin tick(); t++; end
    abort = 1'b1;
    enable = 1'b0;
    tick();
    abort = 1'b0;
    check("abort_wait_still_busy", {31'h0, busy}, 32'h1);
    t = 0;
    while (busy && t < 50) begin tick(); t++; end
    p0 = n_pop;
    repeat (10) tick();
    check("abort_no_status", (n_ok - ok0) + (n_cfail - f0), 0);
    check("abort_bytes_sent", n_acc - a0, 2);
    check("abort_fifo_intact", fifo_q.size(), 1);
    check("abort_paused_no_pop", n_pop - p0, 0);
    check("abort_bytes_left", exp_q.size(), 0);
    done_lat = 1; attempt = 0;
    push_expected(32'h0044_5566, 0, 0);
    ok0 = n_ok;
    enable = 1'b1;
    exec_cmd(p0, lat);
    tick();
    check("resume_latency", lat, 10);
    check("resume_cmd_ok", n_ok - ok0, 1);
    check("resume_bytes_left", exp_q.size(), 0);

    // Abort in SEND before the engine accepts.
    byte_ready = 1'b0;
    a0 = n_acc;
    fifo_q.push_back(32'h0077_8899);
    t = 0;
    while (!byte_valid && t < 50) begin tick(); t++; end
    abort = 1'b1;
    enable = 1'b0;
    tick();
    abort = 1'b0;
    check("abort_send_idle", {30'h0, byte_valid, busy}, 32'h0);
    check("abort_send_no_accept", n_acc - a0, 0);
    byte_ready = 1'b1;
    enable = 1'b1;

    // Abort in DELAY.
    p0 = n_pop;
    fifo_q.push_back(32'h4000_0032);
    t = 0;
    while (n_pop == p0 && t < 50) begin tick(); t++; end
    repeat (5) tick();
    check("delay_busy", {31'h0, busy}, 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_delay_idle", {31'h0, busy}, 32'h0);

    // Asynchronous reset mid-DELAY, then empty FIFO with enable high.
    p0 = n_pop;
    fifo_q.push_back(32'h4000_0028);
    t = 0;
    while (n_pop == p0 && t < 50) begin tick(); t++; end
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {15'h0, fifo_read, byte_valid, byte_start, byte_stop, busy,
                                  cmd_ok, cmd_fail, seq_done, error, byte_data}, 32'h0);
    tick();
    rst = 1'b0;
    p0 = n_pop;
    repeat (20) tick();
    check("empty_no_pop", n_pop - p0, 0);
    check("empty_idle", {31'h0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
